// File: rtl/mobilenet_v1_param_loader.sv
// mobilenet_v1_param_loader
//   Write-side front end for mobilenet_v1_param_cache. It takes a 32-bit
//   valid/ready parameter stream made of packets. Each packet is a header-0
//   beat {end, sel[6:0], count[23:0]}, then a header-1 beat {base address},
//   then count entries of BEATS beats each. Beats are packed into cache-width
//   entries, least significant beat first. Each entry produces one cache
//   write at an incrementing address.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   s_valid/s_ready  : stream handshake; s_data is the 32-bit beat
//   load_clear       : clears sticky load_done / err (a same-cycle set wins)
//   wr_en            : one-cycle cache write strobe
//   wr_sel/addr/data : cache write select / address / entry data; these
//                      hold their value until the next write
//   busy             : a packet is in progress (state other than HDR0)
//   load_done        : sticky; an end-flagged packet has completed
//   err              : sticky; a packet carried an illegal select code
//   entries_written  : wr_en pulse count since reset (wraps)
module mobilenet_v1_param_loader #(
    parameter int WR_DATA_W = 72,
    parameter int ADDR_W    = 20,
    parameter int SEL_W     = 5,
    parameter int NUM_SEL   = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    input  logic                 load_clear,
    output logic                 wr_en,
    output logic [SEL_W-1:0]     wr_sel,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WR_DATA_W-1:0] wr_data,
    output logic                 busy,
    output logic                 load_done,
    output logic                 err,
    output logic [31:0]          entries_written
);

    localparam int BEATS  = (WR_DATA_W + 31) / 32;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // The last beat of an entry goes straight from s_data into wr_data, so
    // only the earlier BEATS-1 beats need to be held.
    localparam int ASM_W  = (BEATS > 1) ? (BEATS - 1) * 32 : 32;

    typedef enum logic [1:0] {
        HDR0 = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                ready_q;
    logic                end_flag;
    logic [6:0]          pkt_sel;
    logic                bad_sel;
    logic [23:0]         entry_cnt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [BIDX_W-1:0]   beat_idx;
    logic [ASM_W-1:0]    asm_q;

    logic                xfer;
    logic                last_beat;
    logic                last_entry;
    logic                write_fire;
    logic                done_set;
    logic                err_set;

    assign s_ready    = ready_q;
    assign busy       = (state != HDR0);
    assign xfer       = s_valid && ready_q;
    assign last_beat  = (beat_idx == BIDX_W'(BEATS - 1));
    assign last_entry = (entry_cnt == 24'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        write_fire = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            HDR0: begin
                if (xfer) begin
                    state_next = HDR1;
                    err_set    = (s_data[30:24] >= 7'(NUM_SEL));
                end
            end
            HDR1: begin
                if (xfer) begin
                    if (entry_cnt == 24'd0) begin
                        state_next = HDR0;
                        done_set   = end_flag;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && last_beat) begin
                    // Illegal-select packets are consumed but never written.
                    write_fire = !bad_sel;
                    if (last_entry) begin
                        state_next = HDR0;
                        done_set   = end_flag;
                    end
                end
            end
            default: state_next = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q         <= 1'b0;
            end_flag        <= 1'b0;
            pkt_sel         <= '0;
            bad_sel         <= 1'b0;
            entry_cnt       <= '0;
            addr_cnt        <= '0;
            beat_idx        <= '0;
            wr_en           <= 1'b0;
            wr_sel          <= '0;
            wr_addr         <= '0;
            wr_data         <= '0;
            load_done       <= 1'b0;
            err             <= 1'b0;
            entries_written <= '0;
        end else begin
            ready_q         <= 1'b1;
            wr_en           <= write_fire;
            entries_written <= entries_written + {31'd0, wr_en};
            load_done       <= done_set | (load_done & ~load_clear);
            err             <= err_set  | (err & ~load_clear);

            if (write_fire) begin
                wr_data <= WR_DATA_W'({s_data, asm_q});
                wr_addr <= addr_cnt;
                wr_sel  <= pkt_sel[SEL_W-1:0];
            end

            if (xfer) begin
                case (state)
                    HDR0: begin
                        end_flag  <= s_data[31];
                        pkt_sel   <= s_data[30:24];
                        entry_cnt <= s_data[23:0];
                        bad_sel   <= (s_data[30:24] >= 7'(NUM_SEL));
                    end
                    HDR1: begin
                        addr_cnt <= s_data[ADDR_W-1:0];
                        beat_idx <= '0;
                    end
                    DATA: begin
                        if (last_beat) begin
                            beat_idx  <= '0;
                            addr_cnt  <= addr_cnt + ADDR_W'(1);
                            entry_cnt <= entry_cnt - 24'd1;
                        end else begin
                            beat_idx <= beat_idx + BIDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Assembly shift register: each new beat enters at the top. After
    // BEATS-1 beats, beat 0 sits in the least significant word. It is left
    // unreset because a reset also clears beat_idx, which discards any
    // partial entry.
    always_ff @(posedge clk) begin
        if (xfer && state == DATA && !last_beat) begin
            asm_q <= ASM_W'({s_data, asm_q} >> 32);
        end
    end

endmodule

// File: tb/tb_mobilenet_v1_param_loader.sv
module tb_mobilenet_v1_param_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        load_clear;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic [19:0] wr_addr;
    logic [71:0] wr_data;
    logic        busy;
    logic        load_done;
    logic        err;
    logic [31:0] entries_written;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          c;
        logic [4:0]  sel;
        logic [19:0] addr;
        logic [71:0] data;
    } wr_t;
    wr_t wq[$];

    mobilenet_v1_param_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .load_clear(load_clear), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .load_done(load_done), .err(err),
        .entries_written(entries_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back('{cyc, wr_sel, wr_addr, wr_data});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake.
    task automatic send(input logic [31:0] d);
        logic ok;
        int   n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) check("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    function automatic logic [71:0] exp_entry(input logic [31:0] p);
        logic [31:0] t;
        t = p ^ 32'h5A5A5A5A;
        return {t[7:0], ~p, p};
    endfunction

    task automatic send_entry(input logic [31:0] p, input int max_gap);
        send(p);
        repeat ($urandom_range(0, max_gap)) tick();
        send(~p);
        repeat ($urandom_range(0, max_gap)) tick();
        send(p ^ 32'h5A5A5A5A);
    endtask

    task automatic check_wr(input string tag, input int i, input logic [4:0] sel,
                            input logic [19:0] addr, input logic [71:0] data);
        if (i >= wq.size()) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            check({tag, "_sel"}, wq[i].sel, sel);
            check({tag, "_addr"}, wq[i].addr, addr);
            check({tag, "_data"}, wq[i].data, data);
        end
    endtask

    task automatic pulse_clear();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; load_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_s_ready", s_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err", err, 0);
        check("rst_entries", entries_written, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", s_ready, 1);

        // Test 1: single DW packet, end=1 sel=7 count=2 base=0x10
        wq.delete();
        send(32'h87000002);
        check("t1_busy_hdr0", busy, 1);
        send(32'h00000010);
        send(32'h11111111); send(32'h22222222); send(32'hAABBCC33);
        check("t1_wr_en_e0", wr_en, 1);
        send(32'h000000FF); send(32'h80000001);
        check("t1_done_early", load_done, 0);
        send(32'hFFFFFF7E);
        check("t1_wr_en_e1", wr_en, 1);
        check("t1_load_done", load_done, 1);
        check("t1_busy_end", busy, 0);
        tick();
        check("t1_wr_en_low", wr_en, 0);
        check("t1_entries", entries_written, 2);
        check("t1_nwr", wq.size(), 2);
        check_wr("t1_w0", 0, 5'd7, 20'h10, 72'h33_22222222_11111111);
        check_wr("t1_w1", 1, 5'd7, 20'h11, 72'h7E_80000001_000000FF);
        if (wq.size() == 2) check("t1_spacing", wq[1].c - wq[0].c, 3);
        pulse_clear();
        check("t1_clear", load_done, 0);

        // Test 2: back-to-back packets, s_valid held high
        wq.delete();
        send(32'h03000001); send(32'h00000005);
        send_entry(32'h01020304, 0);
        send(32'h84000003);
        check("t2_done_mid", load_done, 0);
        send(32'h00000000);
        send_entry(32'h10203040, 0);
        send_entry(32'hDEADBEEF, 0);
        send_entry(32'h0F0F0F0F, 0);
        check("t2_load_done", load_done, 1);
        tick();
        check("t2_nwr", wq.size(), 4);
        check_wr("t2_w0", 0, 5'd3, 20'h5, exp_entry(32'h01020304));
        check_wr("t2_w1", 1, 5'd4, 20'h0, exp_entry(32'h10203040));
        check_wr("t2_w2", 2, 5'd4, 20'h1, exp_entry(32'hDEADBEEF));
        check_wr("t2_w3", 3, 5'd4, 20'h2, exp_entry(32'h0F0F0F0F));
        if (wq.size() == 4) begin
            check("t2_gap_boundary", wq[1].c - wq[0].c, 5);
            check("t2_gap_1", wq[2].c - wq[1].c, 3);
            check("t2_gap_2", wq[3].c - wq[2].c, 3);
        end

        // Test 3: illegal sel=25 count=2, then legal sel=21
        wq.delete();
        send(32'h19000002);
        check("t3_err", err, 1);
        send(32'h00000040);
        send_entry(32'h55555555, 0);
        send_entry(32'h66666666, 0);
        tick();
        check("t3_no_write", wq.size(), 0);
        check("t3_entries", entries_written, 6);
        check("t3_busy", busy, 0);
        send(32'h15000001); send(32'h00000040);
        send_entry(32'h77777777, 0);
        tick();
        check("t3_nwr_legal", wq.size(), 1);
        check_wr("t3_legal", 0, 5'd21, 20'h40, exp_entry(32'h77777777));
        check("t3_err_sticky", err, 1);

        // Test 4: count=0 with end=1
        pulse_clear();
        check("t4_err_clear", err, 0);
        wq.delete();
        send(32'h80000000);
        check("t4_busy", busy, 1);
        send(32'h00000123);
        check("t4_load_done", load_done, 1);
        check("t4_idle", busy, 0);
        tick();
        check("t4_no_write", wq.size(), 0);

        // Test 5: s_valid gaps and address wrap at 0xFFFFF
        pulse_clear();
        wq.delete();
        send(32'h0A000002);
        tick(); tick();
        check("t5_stall_busy", busy, 1);
        send(32'h000FFFFF);
        send_entry(32'h13579BDF, 3);
        repeat (2) tick();
        send_entry(32'h2468ACE0, 3);
        tick();
        check("t5_nwr", wq.size(), 2);
        check_wr("t5_w0", 0, 5'd10, 20'hFFFFF, exp_entry(32'h13579BDF));
        check_wr("t5_w1", 1, 5'd10, 20'h00000, exp_entry(32'h2468ACE0));
        check("t5_entries", entries_written, 9);
        check("t5_done", load_done, 0);

        // Test 6: reset after 2 beats of an entry
        send(32'h81000003); send(32'h00000200);
        send(32'hAAAAAAAA); send(32'hBBBBBBBB);
        wq.delete();
        rst = 1'b1;
        tick();
        check("t6_rst_s_ready", s_ready, 0);
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_wr_sel", wr_sel, 0);
        check("t6_rst_wr_addr", wr_addr, 0);
        check("t6_rst_wr_data", wr_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_entries", entries_written, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("t6_no_spurious", wq.size(), 0);
        check("t6_busy_idle", busy, 0);
        send(32'h82000001); send(32'h00000003);
        send(32'hCAFEF00D); send(32'h12345678);
        load_clear = 1'b1;
        send(32'h0000009C);
        load_clear = 1'b0;
        check("t6_set_wins", load_done, 1);
        tick();
        check("t6_done_hold", load_done, 1);
        check("t6_nwr", wq.size(), 1);
        check_wr("t6_w0", 0, 5'd2, 20'h3, 72'h9C_12345678_CAFEF00D);
        check("t6_entries", entries_written, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
